register_file_param: RTL and testbench



---
 rtl/register_file_param.sv | 139 +++++++++++++
 tb/tb_register_file_param.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_param.sv
// Parametrised 2-read/1-write register file with write-first bypass and a sequential bulk-clear engine.
// Build option: define REGISTER_FILE_ZERO_REG_EN to hardwire entry 0 to zero.
module register_file_param #(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    ADDR_WIDTH  = 3,
    parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] read_address_1,
    input  logic [ADDR_WIDTH-1:0] read_address_2,
    input  logic                  read_enable,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  write_enable,
    input  logic                  clear_start,
    output logic [DATA_WIDTH-1:0] read_data_1,
    output logic [DATA_WIDTH-1:0] read_data_2,
    output logic                  read_valid,
    output logic                  busy,
    output logic                  clear_done,
    output logic [1:0]            o_dbg_state
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [ADDR_WIDTH-1:0] r_ptr;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_1;
    logic [DATA_WIDTH-1:0] r_rd_2;
    logic                  r_valid;
    logic                  w_idle;
    logic                  w_wr_en;
    logic                  w_rd_en;
    logic [DATA_WIDTH-1:0] w_rd_1;
    logic [DATA_WIDTH-1:0] w_rd_2;

    assign w_idle  = (r_state == S_IDLE);
    assign w_rd_en = w_idle && read_enable;

`ifdef REGISTER_FILE_ZERO_REG_EN
    assign w_wr_en = w_idle && write_enable && (write_address != '0);
`else
    assign w_wr_en = w_idle && write_enable;
`endif

    // Read handshake: read_enable is a one-cycle request sampled at the edge (honoured
    // only while idle); read_valid is high for exactly the cycle after an honoured request.
    always_comb begin
        w_rd_1 = r_mem[read_address_1];
        w_rd_2 = r_mem[read_address_2];
        if (write_enable && (write_address == read_address_1)) begin
            w_rd_1 = write_data;
        end
        if (write_enable && (write_address == read_address_2)) begin
            w_rd_2 = write_data;
        end
`ifdef REGISTER_FILE_ZERO_REG_EN
        if (read_address_1 == '0) begin
            w_rd_1 = '0;
        end
        if (read_address_2 == '0) begin
            w_rd_2 = '0;
        end
`endif
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (clear_start) begin
                    w_next_state = S_CLEAR;
                end
            end
            S_CLEAR: begin
                if (r_ptr == ADDR_WIDTH'(DEPTH - 1)) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // The clear sweep and normal writes never overlap: writes only land while idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= RESET_VALUE;
            end
            r_ptr   <= '0;
            r_rd_1  <= '0;
            r_rd_2  <= '0;
            r_valid <= 1'b0;
        end else begin
            if (r_state == S_CLEAR) begin
                r_mem[r_ptr] <= RESET_VALUE;
                r_ptr        <= r_ptr + 1'b1;
            end else if (w_wr_en) begin
                r_mem[write_address] <= write_data;
            end
            if (w_idle && clear_start) begin
                r_ptr <= '0;
            end
            if (w_rd_en) begin
                r_rd_1  <= w_rd_1;
                r_rd_2  <= w_rd_2;
                r_valid <= 1'b1;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign read_data_1 = r_rd_1;
    assign read_data_2 = r_rd_2;
    assign read_valid  = r_valid;
    assign busy        = (r_state != S_IDLE);
    assign clear_done  = (r_state == S_DONE);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_register_file_param.sv
// Directed bench for register_file_param: a behavioural reference model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_register_file_param;

    localparam int DW    = 8;
    localparam int AW    = 3;
    localparam int DEPTH = 2 ** AW;
    localparam logic [DW-1:0] RV = '0;
`ifdef REGISTER_FILE_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [AW-1:0] read_address_1 = '0;
    logic [AW-1:0] read_address_2 = '0;
    logic          read_enable = 1'b0;
    logic [AW-1:0] write_address = '0;
    logic [DW-1:0] write_data = '0;
    logic          write_enable = 1'b0;
    logic          clear_start = 1'b0;
    logic [DW-1:0] read_data_1;
    logic [DW-1:0] read_data_2;
    logic          read_valid;
    logic          busy;
    logic          clear_done;
    logic [1:0]    dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    register_file_param #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .RESET_VALUE(RV)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .read_address_1(read_address_1),
        .read_address_2(read_address_2),
        .read_enable   (read_enable),
        .write_address (write_address),
        .write_data    (write_data),
        .write_enable  (write_enable),
        .clear_start   (clear_start),
        .read_data_1   (read_data_1),
        .read_data_2   (read_data_2),
        .read_valid    (read_valid),
        .busy          (busy),
        .clear_done    (clear_done),
        .o_dbg_state   (dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] m_rd1 = '0;
    logic [DW-1:0] m_rd2 = '0;
    logic          m_valid = 1'b0;
    int            m_left = 0;  // cycles of busy remaining

    function automatic logic [DW-1:0] model_read(input logic [AW-1:0] a);
        if (ZERO_REG && a == 0) return '0;
        if (write_enable && write_address == a) return write_data;
        return m_mem[a];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) m_mem[i] = RV;
            m_rd1 = '0;
            m_rd2 = '0;
            m_valid = 1'b0;
            m_left = 0;
        end else if (m_left == 0) begin
            if (read_enable) begin
                m_rd1 = model_read(read_address_1);
                m_rd2 = model_read(read_address_2);
                m_valid = 1'b1;
            end else begin
                m_valid = 1'b0;
            end
            if (write_enable && !(ZERO_REG && write_address == 0))
                m_mem[write_address] = write_data;
            if (clear_start) begin
                // Reads and writes are blocked while busy, so only the end result matters.
                for (int i = 0; i < DEPTH; i++) m_mem[i] = RV;
                m_left = DEPTH + 1;
            end
        end else begin
            m_valid = 1'b0;
            m_left--;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_rd1", read_data_1, m_rd1);
            chk("model_rd2", read_data_2, m_rd2);
            chk("model_valid", read_valid, m_valid);
            chk("model_busy", busy, m_left != 0);
            chk("model_done", clear_done, m_left == 1);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        write_enable = 1'b0;
        read_enable  = 1'b0;
        clear_start  = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        idle_inputs();
        write_enable = 1'b1;
        write_address = a;
        write_data = d;
        step();
    endtask

    task automatic do_read(input logic [AW-1:0] a1, input logic [AW-1:0] a2);
        idle_inputs();
        read_enable = 1'b1;
        read_address_1 = a1;
        read_address_2 = a2;
        step();
    endtask

    // ---------------- stimulus ----------------
    int busy_cycles;
    int done_pulses;

    initial begin
        rst_n = 1'b0;
        step();
        step();
        chk_en = 1'b1;
        chk("rst_rd1", read_data_1, 0);
        chk("rst_valid", read_valid, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;

        // 1: reset then read
        do_read(3'd0, 3'd1);
        chk("t1_rd1", read_data_1, 8'h00);
        chk("t1_rd2", read_data_2, 8'h00);
        chk("t1_valid", read_valid, 1);

        // 2: write/read, then hold
        do_write(3'd2, 8'hAA);
        do_write(3'd5, 8'h55);
        do_read(3'd2, 3'd5);
        chk("t2_rd1", read_data_1, 8'hAA);
        chk("t2_rd2", read_data_2, 8'h55);
        chk("t2_valid", read_valid, 1);
        idle_inputs();
        step();
        chk("t2_hold_rd1", read_data_1, 8'hAA);
        chk("t2_hold_valid", read_valid, 0);

        // 3: bypass on both ports, then on one port only
        idle_inputs();
        write_enable = 1'b1; write_address = 3'd4; write_data = 8'h3C;
        read_enable = 1'b1; read_address_1 = 3'd4; read_address_2 = 3'd4;
        step();
        chk("t3_byp_rd1", read_data_1, 8'h3C);
        chk("t3_byp_rd2", read_data_2, 8'h3C);
        write_address = 3'd6; write_data = 8'h99;
        read_address_1 = 3'd6; read_address_2 = 3'd2;
        step();
        chk("t3_byp1_rd1", read_data_1, 8'h99);
        chk("t3_byp1_rd2", read_data_2, 8'hAA);

        // 4: fill, clear (with a same-edge write), write/read during clear
        for (int i = 0; i < DEPTH; i++) do_write(AW'(i), DW'((i + 1) * 8'h11));
        do_read(3'd1, 3'd7);
        chk("t4_fill_rd1", read_data_1, 8'h22);
        chk("t4_fill_rd2", read_data_2, 8'h88);
        idle_inputs();
        clear_start = 1'b1;
        write_enable = 1'b1; write_address = 3'd7; write_data = 8'hEE;
        step();
        busy_cycles = 0;
        done_pulses = 0;
        for (int k = 0; k < 16; k++) begin
            if (busy) busy_cycles++;
            if (clear_done) done_pulses++;
            if (k == 3) chk("t4_valid_in_clear", read_valid, 0);
            idle_inputs();
            if (k == 2) begin
                write_enable = 1'b1; write_address = 3'd3; write_data = 8'hFF;
                read_enable = 1'b1; read_address_1 = 3'd3; read_address_2 = 3'd3;
            end
            step();
        end
        chk("t4_busy_cycles", busy_cycles, 9);
        chk("t4_done_pulses", done_pulses, 1);
        for (int i = 0; i < DEPTH; i++) begin
            do_read(AW'(i), AW'(DEPTH - 1 - i));
            chk("t4_after_rd1", read_data_1, 8'h00);
            chk("t4_after_rd2", read_data_2, 8'h00);
        end

        // 5: reset mid-clear
        for (int i = 1; i < DEPTH; i++) do_write(AW'(i), 8'h5A);
        idle_inputs();
        clear_start = 1'b1;
        step();
        idle_inputs();
        step();
        step();
        chk("t5_busy_pre", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("t5_busy_rst", busy, 0);
        chk("t5_done_rst", clear_done, 0);
        step();
        rst_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            do_read(AW'(i), AW'(i));
            chk("t5_after_rd1", read_data_1, 8'h00);
        end

        // 6: entry 0 write with same-edge read, then plain read
        idle_inputs();
        write_enable = 1'b1; write_address = 3'd0; write_data = 8'h77;
        read_enable = 1'b1; read_address_1 = 3'd0; read_address_2 = 3'd0;
        step();
        chk("t6_byp_rd1", read_data_1, ZERO_REG ? 8'h00 : 8'h77);
        chk("t6_byp_rd2", read_data_2, ZERO_REG ? 8'h00 : 8'h77);
        do_read(3'd0, 3'd6);
        chk("t6_rd_addr0", read_data_1, ZERO_REG ? 8'h00 : 8'h77);
        chk("t6_rd_addr6", read_data_2, 8'h00);

        idle_inputs();
        step();
        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
